// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-side PC controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: redirect, hold, +4 step and target alignment.
// Optional feature macro: PC_MISALIGN_TRAP_EN (keep raw target, flag misalignment).
module pc_next_sel
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  pc_state_e         state_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              stall_i,
  input  logic              pc_sel_i,
  input  logic [31:0]       br_pc_i,
  output logic [PC_W-1:0]   pc_d_o,
  output logic              misaligned_o
);

  logic [PC_W-1:0] target;
  logic            unused_bits;

  // Upper target bits fall outside the fetch address space and are dropped.
  assign unused_bits = ^{br_pc_i[31:PC_W], br_pc_i[1:0]};

`ifdef PC_MISALIGN_TRAP_EN
  assign target       = br_pc_i[PC_W-1:0];
  assign misaligned_o = (br_pc_i[1:0] != 2'b00);
`else
  assign target       = {br_pc_i[PC_W-1:2], 2'b00};
  assign misaligned_o = 1'b0;
`endif

  always_comb begin
    pc_d_o = pc_i;
    if (state_i == RUN) begin
      if (pc_sel_i) begin
        pc_d_o = target;
      end else if (!stall_i) begin
        pc_d_o = pc_i + PC_W'(PC_STEP);
      end
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: BOOT -> RUN -> HALT sequencing, redirects, stalls and flushes.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect parks core, sets Misalign).
module fetch_pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic            Halt,
  input  logic [31:0]     BrPC,
  output logic [PC_W-1:0] PC,
  output logic            Fetch_Valid,
  output logic            Flush_IfId,
  output logic            Flush_IdEx,
  output logic            Halted,
  output logic            Misalign
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            halted_q, halted_d;
  logic            misalign_q, misalign_d;
  logic            misaligned;
  logic            redirect;

  pc_next_sel #(.PC_W(PC_W)) u_next_sel (
    .state_i      (state_q),
    .pc_i         (pc_q),
    .stall_i      (Stall),
    .pc_sel_i     (PcSel),
    .br_pc_i      (BrPC),
    .pc_d_o       (pc_d),
    .misaligned_o (misaligned)
  );

  // Redirect wins over Stall; only meaningful while running.
  assign redirect = PcSel && (state_q == RUN);

  always_comb begin
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    halted_d      = halted_q;
    misalign_d    = misalign_q;
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        if (PcSel && (Halt || misaligned)) begin
          state_d       = HALT;
          fetch_valid_d = 1'b0;
          halted_d      = 1'b1;
          misalign_d    = misalign_q | misaligned;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d       = BOOT;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= '0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
      misalign_q    <= misalign_d;
    end
  end

  assign PC          = pc_q;
  assign Fetch_Valid = fetch_valid_q;
  assign Halted      = halted_q;
  assign Misalign    = misalign_q;
  assign Flush_IfId  = reset && redirect;
  assign Flush_IdEx  = reset && redirect;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl (PC_W = 9).
module tb_fetch_pc_ctrl;

  localparam int PC_W = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            Stall;
  logic            PcSel;
  logic            Halt;
  logic [31:0]     BrPC;
  logic [PC_W-1:0] PC;
  logic            Fetch_Valid;
  logic            Flush_IfId;
  logic            Flush_IdEx;
  logic            Halted;
  logic            Misalign;

  int total = 0;
  int bad   = 0;

  fetch_pc_ctrl #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .Stall       (Stall),
    .PcSel       (PcSel),
    .Halt        (Halt),
    .BrPC        (BrPC),
    .PC          (PC),
    .Fetch_Valid (Fetch_Valid),
    .Flush_IfId  (Flush_IfId),
    .Flush_IdEx  (Flush_IdEx),
    .Halted      (Halted),
    .Misalign    (Misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; Stall = 1'b0; PcSel = 1'b1; Halt = 1'b0; BrPC = 32'h40;
    #1;
    total++; if (Flush_IfId !== 1'b0 || Flush_IdEx !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b%b exp=00", Flush_IfId, Flush_IdEx); end
    tick(); tick();
    total++; if (PC !== 9'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", PC); end
    total++; if (Fetch_Valid !== 1'b0 || Halted !== 1'b0 || Misalign !== 1'b0) begin bad++; $display("FAIL reset_flags got fv=%b h=%b m=%b exp 000", Fetch_Valid, Halted, Misalign); end
    // release with a PcSel still up: BOOT must ignore it
    reset = 1'b1;
    #1;
    total++; if (Flush_IfId !== 1'b0) begin bad++; $display("FAIL boot_no_flush got=%b exp=0", Flush_IfId); end
    total++; if (PC !== 9'h000 || Fetch_Valid !== 1'b0) begin bad++; $display("FAIL boot_pc got pc=%h fv=%b exp 000/0", PC, Fetch_Valid); end
    tick();
    PcSel = 1'b0;
    total++; if (PC !== 9'h000 || Fetch_Valid !== 1'b1) begin bad++; $display("FAIL run0 got pc=%h fv=%b exp 000/1", PC, Fetch_Valid); end
    tick();
    total++; if (PC !== 9'h004) begin bad++; $display("FAIL run1 got=%h exp=004", PC); end
    tick();
    total++; if (PC !== 9'h008 || Fetch_Valid !== 1'b1) begin bad++; $display("FAIL run2 got pc=%h fv=%b exp 008/1", PC, Fetch_Valid); end
  endtask

  task automatic test_redirect();
    tick(); tick();
    total++; if (PC !== 9'h010) begin bad++; $display("FAIL pre_redirect got=%h exp=010", PC); end
    PcSel = 1'b1; BrPC = 32'h40;
    #1;
    total++; if (Flush_IfId !== 1'b1 || Flush_IdEx !== 1'b1) begin bad++; $display("FAIL redirect_flush got=%b%b exp=11", Flush_IfId, Flush_IdEx); end
    tick();
    PcSel = 1'b0;
    #1;
    total++; if (PC !== 9'h040) begin bad++; $display("FAIL redirect_pc got=%h exp=040", PC); end
    total++; if (Flush_IfId !== 1'b0) begin bad++; $display("FAIL redirect_flush_clear got=%b exp=0", Flush_IfId); end
  endtask

  task automatic test_stall();
    Stall = 1'b1; PcSel = 1'b1; BrPC = 32'h80;
    #1;
    total++; if (Flush_IfId !== 1'b1 || Flush_IdEx !== 1'b1) begin bad++; $display("FAIL stall_redirect_flush got=%b%b exp=11", Flush_IfId, Flush_IdEx); end
    tick();
    PcSel = 1'b0;
    total++; if (PC !== 9'h080) begin bad++; $display("FAIL stall_redirect_pc got=%h exp=080", PC); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (PC !== 9'h080 || Flush_IfId !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d] got pc=%h fl=%b exp 080/0", i, PC, Flush_IfId); end
    end
    Stall = 1'b0;
    tick();
    total++; if (PC !== 9'h084) begin bad++; $display("FAIL stall_release got=%h exp=084", PC); end
  endtask

  task automatic test_wrap();
    PcSel = 1'b1; BrPC = 32'h1F8;
    tick();
    PcSel = 1'b0;
    total++; if (PC !== 9'h1F8) begin bad++; $display("FAIL wrap_load got=%h exp=1f8", PC); end
    tick();
    total++; if (PC !== 9'h1FC) begin bad++; $display("FAIL wrap_1fc got=%h exp=1fc", PC); end
    tick();
    total++; if (PC !== 9'h000) begin bad++; $display("FAIL wrap_000 got=%h exp=000", PC); end
    PcSel = 1'b1; BrPC = 32'hFFFF_F104;
    tick();
    PcSel = 1'b0;
    total++; if (PC !== 9'h104 || Halted !== 1'b0) begin bad++; $display("FAIL wide_target got pc=%h h=%b exp 104/0", PC, Halted); end
  endtask

  task automatic test_misalign();
    PcSel = 1'b1; BrPC = 32'h42;
    #1;
    total++; if (Flush_IfId !== 1'b1 || Flush_IdEx !== 1'b1) begin bad++; $display("FAIL misalign_flush got=%b%b exp=11", Flush_IfId, Flush_IdEx); end
    tick();
    PcSel = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    total++; if (PC !== 9'h042 || Halted !== 1'b1 || Misalign !== 1'b1 || Fetch_Valid !== 1'b0) begin bad++; $display("FAIL misalign_trap got pc=%h h=%b m=%b fv=%b exp 042/1/1/0", PC, Halted, Misalign, Fetch_Valid); end
    tick();
    total++; if (PC !== 9'h042 || Misalign !== 1'b1) begin bad++; $display("FAIL misalign_sticky got pc=%h m=%b exp 042/1", PC, Misalign); end
`else
    total++; if (PC !== 9'h040 || Halted !== 1'b0 || Misalign !== 1'b0 || Fetch_Valid !== 1'b1) begin bad++; $display("FAIL misalign_align got pc=%h h=%b m=%b fv=%b exp 040/0/0/1", PC, Halted, Misalign, Fetch_Valid); end
    tick();
    total++; if (PC !== 9'h044) begin bad++; $display("FAIL misalign_still_run got=%h exp=044", PC); end
`endif
  endtask

  task automatic test_halt();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    total++; if (PC !== 9'h000 || Fetch_Valid !== 1'b1 || Misalign !== 1'b0) begin bad++; $display("FAIL halt_prep got pc=%h fv=%b m=%b exp 000/1/0", PC, Fetch_Valid, Misalign); end
    PcSel = 1'b1; Halt = 1'b1; BrPC = 32'h0C;
    #1;
    total++; if (Flush_IfId !== 1'b1 || Flush_IdEx !== 1'b1) begin bad++; $display("FAIL halt_flush got=%b%b exp=11", Flush_IfId, Flush_IdEx); end
    tick();
    total++; if (PC !== 9'h00C || Halted !== 1'b1 || Fetch_Valid !== 1'b0) begin bad++; $display("FAIL halt_enter got pc=%h h=%b fv=%b exp 00c/1/0", PC, Halted, Fetch_Valid); end
    Halt = 1'b0; Stall = 1'b1; BrPC = 32'h100;
    #1;
    total++; if (Flush_IfId !== 1'b0 || Flush_IdEx !== 1'b0) begin bad++; $display("FAIL halt_no_flush got=%b%b exp=00", Flush_IfId, Flush_IdEx); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) Stall = 1'b0;
      total++; if (PC !== 9'h00C || Halted !== 1'b1 || Fetch_Valid !== 1'b0) begin bad++; $display("FAIL halt_frozen[%0d] got pc=%h h=%b fv=%b exp 00c/1/0", i, PC, Halted, Fetch_Valid); end
    end
    // reset from HALT while a redirect is still being presented
    reset = 1'b0;
    #1;
    total++; if (Flush_IfId !== 1'b0) begin bad++; $display("FAIL halt_reset_flush got=%b exp=0", Flush_IfId); end
    tick();
    total++; if (PC !== 9'h000 || Halted !== 1'b0 || Fetch_Valid !== 1'b0 || Misalign !== 1'b0) begin bad++; $display("FAIL halt_reset got pc=%h h=%b fv=%b m=%b exp 000/0/0/0", PC, Halted, Fetch_Valid, Misalign); end
    PcSel = 1'b0;
    reset = 1'b1;
    tick(); tick();
    total++; if (PC !== 9'h004 || Fetch_Valid !== 1'b1) begin bad++; $display("FAIL halt_restart got pc=%h fv=%b exp 004/1", PC, Fetch_Valid); end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall();
    test_wrap();
    test_misalign();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
